// File: rtl/tcam_ctrl.sv
// Front-end controller for a 16x16 TCAM: arbitrates config writes against lookups,
// sequences the TCAM strobes and returns held lookup responses with hit/miss statistics.
module tcam_ctrl #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int TCAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] wr_mask,
    input  logic [AW-1:0] wr_addr,
    input  logic          lk_valid,
    output logic          lk_ready,
    input  logic [DW-1:0] lk_key,
    output logic          rs_valid,
    input  logic          rs_ready,
    output logic          rs_match,
    output logic [DW-1:0] rs_num,
    output logic          tc_r_e,
    output logic          tc_w_e,
    output logic [DW-1:0] tc_data_in,
    output logic [DW-1:0] tc_mask,
    output logic [AW-1:0] tc_addr_in,
    input  logic          tc_match,
    input  logic [DW-1:0] tc_matched_num,
    output logic          busy,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic          r_last_lk;
    logic [2:0]    r_cnt;
    logic          r_tc_r_e;
    logic          r_tc_w_e;
    logic [DW-1:0] r_tc_data;
    logic [DW-1:0] r_tc_mask;
    logic [AW-1:0] r_tc_addr;
    logic          r_rs_valid;
    logic          r_rs_match;
    logic [DW-1:0] r_rs_num;
    logic [15:0]   r_hit_cnt;
    logic [15:0]   r_miss_cnt;

    logic w_idle;
    logic w_wr_go;
    logic w_lk_go;

    // On a tie the side that did not win the previous grant goes first.
    assign w_idle  = rstN && (r_state == S_IDLE);
    assign w_wr_go = w_idle && wr_valid && (!lk_valid || r_last_lk);
    assign w_lk_go = w_idle && lk_valid && (!wr_valid || !r_last_lk);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state    <= S_IDLE;
            r_last_lk  <= 1'b1;
            r_cnt      <= '0;
            r_tc_r_e   <= 1'b0;
            r_tc_w_e   <= 1'b0;
            r_tc_data  <= '0;
            r_tc_mask  <= '0;
            r_tc_addr  <= '0;
            r_rs_valid <= 1'b0;
            r_rs_match <= 1'b0;
            r_rs_num   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_go) begin
                        r_tc_w_e  <= 1'b1;
                        r_tc_data <= wr_data;
                        r_tc_mask <= wr_mask;
                        r_tc_addr <= wr_addr;
                        r_last_lk <= 1'b0;
                        r_state   <= S_WRITE;
                    end else if (w_lk_go) begin
                        r_tc_r_e  <= 1'b1;
                        r_tc_data <= lk_key;
                        r_tc_mask <= '0;
                        r_tc_addr <= '0;
                        r_last_lk <= 1'b1;
                        r_state   <= S_READ;
                    end
                end
                S_WRITE: begin
                    r_tc_w_e <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_READ: begin
                    r_tc_r_e <= 1'b0;
                    r_cnt    <= 3'(TCAM_LAT - 1);
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        // The TCAM result is valid at this edge; capture and count it.
                        r_rs_match <= tc_match;
                        r_rs_num   <= tc_matched_num;
                        r_rs_valid <= 1'b1;
                        if (tc_match) begin
                            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
                        end else begin
                            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rs_ready) begin
                        r_rs_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_ready   = w_wr_go;
    assign lk_ready   = w_lk_go;
    assign rs_valid   = r_rs_valid;
    assign rs_match   = r_rs_match;
    assign rs_num     = r_rs_num;
    assign tc_r_e     = r_tc_r_e;
    assign tc_w_e     = r_tc_w_e;
    assign tc_data_in = r_tc_data;
    assign tc_mask    = r_tc_mask;
    assign tc_addr_in = r_tc_addr;
    assign busy       = (r_state != S_IDLE);
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Bench for tcam_ctrl: a TCAM_LAT=1 instance backed by a ternary TCAM stub and a
// TCAM_LAT=3 instance with a key-derived stub for latency and mid-operation reset.
module tb_tcam_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- instance with TCAM_LAT = 1 ----------------
    logic        rstN, wr_valid, wr_ready, lk_valid, lk_ready, rs_valid, rs_ready, rs_match;
    logic [15:0] wr_data, wr_mask, lk_key, rs_num, tc_data_in, tc_mask, tc_matched_num;
    logic [3:0]  wr_addr, tc_addr_in;
    logic        tc_r_e, tc_w_e, tc_match, busy;
    logic [15:0] hit_cnt, miss_cnt;

    tcam_ctrl #(.DW(16), .AW(4), .TCAM_LAT(1)) u_dut (
        .clk(clk), .rstN(rstN),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
        .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_match(rs_match), .rs_num(rs_num),
        .tc_r_e(tc_r_e), .tc_w_e(tc_w_e), .tc_data_in(tc_data_in), .tc_mask(tc_mask),
        .tc_addr_in(tc_addr_in), .tc_match(tc_match), .tc_matched_num(tc_matched_num),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // TCAM stub (mask bit 1 = don't care, lowest matching index wins) and bench shadow copy.
    logic [15:0] st_d [16];
    logic [15:0] st_m [16];
    logic        st_v [16];
    logic [15:0] sh_d [16];
    logic [15:0] sh_m [16];
    logic        sh_v [16];
    logic        p_v = 1'b0;
    logic        p_m = 1'b0;
    logic [15:0] p_n = 16'h0;

    function automatic logic [16:0] search(input bit use_shadow, input logic [15:0] key);
        for (int i = 0; i < 16; i++) begin
            if (use_shadow) begin
                if (sh_v[i] && (((sh_d[i] ^ key) & ~sh_m[i]) == 16'h0)) return {1'b1, 16'(i)};
            end else begin
                if (st_v[i] === 1'b1 && (((st_d[i] ^ key) & ~st_m[i]) == 16'h0)) return {1'b1, 16'(i)};
            end
        end
        return 17'h0;
    endfunction

    always @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < 16; i++) st_v[i] <= 1'b0;
        end else if (tc_w_e) begin
            st_d[tc_addr_in] <= tc_data_in;
            st_m[tc_addr_in] <= tc_mask;
            st_v[tc_addr_in] <= 1'b1;
        end
        p_v <= tc_r_e;
        if (tc_r_e) {p_m, p_n} <= search(1'b0, tc_data_in);
    end
    // Outside the one valid cycle the stub shows junk so a mistimed capture is visible.
    assign tc_match       = p_v ? p_m : 1'b0;
    assign tc_matched_num = p_v ? p_n : 16'hDEAD;

    // Strobe monitor.
    logic prev_w = 1'b0;
    logic prev_r = 1'b0;
    int   n_wpulse = 0;
    int   n_rpulse = 0;
    int   wq[$];
    always @(negedge clk) begin
        if (rstN && (tc_w_e || tc_r_e)) begin
            chk("strobe_overlap", 32'(tc_w_e & tc_r_e), 32'd0);
            chk("strobe_repeat", 32'((tc_w_e & prev_w) | (tc_r_e & prev_r)), 32'd0);
            if (tc_w_e) wq.push_back(cyc);
        end
        if (rstN && tc_w_e) n_wpulse <= n_wpulse + 1;
        if (rstN && tc_r_e) n_rpulse <= n_rpulse + 1;
        prev_w <= tc_w_e;
        prev_r <= tc_r_e;
    end

    // Bench model state.
    bit m_last_lk = 1'b1;
    int exp_hit   = 0;
    int exp_miss  = 0;
    int n_wr      = 0;
    int n_lk      = 0;

    // One grant on the LAT=1 instance, followed through to completion.
    task automatic step(input bit wv, input bit lv, input logic [15:0] wd, input logic [15:0] wm,
                        input logic [3:0] wa, input logic [15:0] key, input int hold,
                        output bit g_lk, output logic m_o, output logic [15:0] n_o);
        bit          exp_lk, got;
        int          acc;
        logic [16:0] e;
        logic        m0;
        logic [15:0] n0;
        g_lk = 1'b0; m_o = 1'b0; n_o = 16'h0;
        @(negedge clk);
        wr_valid = wv; wr_data = wd; wr_mask = wm; wr_addr = wa;
        lk_valid = lv; lk_key = key;
        #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wr_ready || lk_ready) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!got) begin
            chk("grant_timeout", 32'd0, 32'd1);
            wr_valid = 1'b0; lk_valid = 1'b0;
            return;
        end
        exp_lk = lv && !(wv && m_last_lk);
        g_lk   = lk_ready;
        chk("grant_side", 32'(lk_ready), 32'(exp_lk));
        chk("grant_excl", 32'(wr_ready & lk_ready), 32'd0);
        acc = cyc;
        @(negedge clk);
        wr_valid = 1'b0; lk_valid = 1'b0;
        if (!g_lk) begin
            $display("txn W addr=%0d data=%h mask=%h", wa, wd, wm);
            chk("wr_we", 32'(tc_w_e), 32'd1);
            chk("wr_re", 32'(tc_r_e), 32'd0);
            chk("wr_data", 32'(tc_data_in), 32'(wd));
            chk("wr_mask", 32'(tc_mask), 32'(wm));
            chk("wr_addr", 32'(tc_addr_in), 32'(wa));
            chk("wr_busy", 32'(busy), 32'd1);
            sh_d[wa] = wd; sh_m[wa] = wm; sh_v[wa] = 1'b1;
            m_last_lk = 1'b0;
            n_wr++;
        end else begin
            m_last_lk = 1'b1;
            n_lk++;
            chk("lk_re", 32'(tc_r_e), 32'd1);
            chk("lk_we", 32'(tc_w_e), 32'd0);
            chk("lk_data", 32'(tc_data_in), 32'(key));
            chk("lk_mask", 32'(tc_mask), 32'd0);
            chk("lk_addr", 32'(tc_addr_in), 32'd0);
            e = search(1'b1, key);
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (rs_valid) begin got = 1'b1; break; end
                @(negedge clk);
            end
            if (!got) begin
                chk("rs_timeout", 32'd0, 32'd1);
                return;
            end
            chk("rs_latency", 32'(cyc - acc), 32'd3);
            m0 = rs_match; n0 = rs_num;
            for (int i = 0; i < hold; i++) begin
                lk_valid = 1'b1;
                #1;
                chk("bp_lk_ready", 32'(lk_ready), 32'd0);
                @(negedge clk);
                chk("bp_rs_valid", 32'(rs_valid), 32'd1);
                chk("bp_rs_match", 32'(rs_match), 32'(m0));
                chk("bp_rs_num", 32'(rs_num), 32'(n0));
            end
            lk_valid = 1'b0;
            rs_ready = 1'b1;
            @(negedge clk);
            rs_ready = 1'b0;
            chk("rs_drop", 32'(rs_valid), 32'd0);
            chk("rs_idle", 32'(busy), 32'd0);
            chk("rs_match", 32'(m0), 32'(e[16]));
            chk("rs_num", 32'(n0), 32'(e[15:0]));
            if (e[16]) exp_hit++; else exp_miss++;
            chk("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
            chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
            m_o = m0; n_o = n0;
            $display("txn L key=%h match=%0d num=%h hold=%0d", key, m0, n0, hold);
        end
    endtask

    // ---------------- instance with TCAM_LAT = 3 ----------------
    logic        b_rstN, b_wr_valid, b_wr_ready, b_lk_valid, b_lk_ready, b_rs_valid, b_rs_ready;
    logic        b_rs_match, b_tc_r_e, b_tc_w_e, b_tc_match, b_busy;
    logic [15:0] b_wr_data, b_wr_mask, b_lk_key, b_rs_num, b_tc_data_in, b_tc_mask, b_tc_matched_num;
    logic [3:0]  b_wr_addr, b_tc_addr_in;
    logic [15:0] b_hit_cnt, b_miss_cnt;

    tcam_ctrl #(.DW(16), .AW(4), .TCAM_LAT(3)) u_dut3 (
        .clk(clk), .rstN(b_rstN),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data), .wr_mask(b_wr_mask),
        .wr_addr(b_wr_addr), .lk_valid(b_lk_valid), .lk_ready(b_lk_ready), .lk_key(b_lk_key),
        .rs_valid(b_rs_valid), .rs_ready(b_rs_ready), .rs_match(b_rs_match), .rs_num(b_rs_num),
        .tc_r_e(b_tc_r_e), .tc_w_e(b_tc_w_e), .tc_data_in(b_tc_data_in), .tc_mask(b_tc_mask),
        .tc_addr_in(b_tc_addr_in), .tc_match(b_tc_match), .tc_matched_num(b_tc_matched_num),
        .busy(b_busy), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
    );

    // Three-cycle stub: match = key[0], num = key ^ 5A5A.
    logic [2:0]  q_v = 3'b000;
    logic [15:0] q_k [3];
    always @(posedge clk) begin
        q_v    <= {q_v[1:0], b_tc_r_e};
        q_k[0] <= b_tc_data_in;
        q_k[1] <= q_k[0];
        q_k[2] <= q_k[1];
    end
    assign b_tc_match       = q_v[2] ? q_k[2][0] : 1'b0;
    assign b_tc_matched_num = q_v[2] ? (q_k[2] ^ 16'h5A5A) : 16'hDEAD;

    typedef struct {
        logic [15:0] key;
        logic        m;
        logic [15:0] n;
        int          hold;
    } lk_vec_t;

    lk_vec_t vec [4];

    initial begin
        bit          g;
        logic        m;
        logic [15:0] n;
        logic [15:0] rd, rm, rk;
        logic [3:0]  ra;
        int          op, j, acc;
        bit          got, seen;

        vec[0] = '{key: 16'hD3C9, m: 1'b1, n: 16'h0002, hold: 0};
        vec[1] = '{key: 16'h0000, m: 1'b0, n: 16'h0000, hold: 5};
        vec[2] = '{key: 16'hABCD, m: 1'b1, n: 16'h0000, hold: 1};
        vec[3] = '{key: 16'hC3EF, m: 1'b1, n: 16'h0001, hold: 0};

        for (int i = 0; i < 16; i++) begin sh_d[i] = 16'h0; sh_m[i] = 16'h0; sh_v[i] = 1'b0; end
        rstN = 1'b0; wr_valid = 1'b1; lk_valid = 1'b1; rs_ready = 1'b0;
        wr_data = 16'h1111; wr_mask = 16'h2222; wr_addr = 4'h3; lk_key = 16'h4444;
        b_rstN = 1'b0; b_wr_valid = 1'b0; b_lk_valid = 1'b0; b_rs_ready = 1'b0;
        b_wr_data = 16'h0; b_wr_mask = 16'h0; b_wr_addr = 4'h0; b_lk_key = 16'h0;

        // Reset with both requesters active.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_wr_ready", 32'(wr_ready), 32'd0);
            chk("rst_lk_ready", 32'(lk_ready), 32'd0);
            chk("rst_flags", 32'({tc_r_e, tc_w_e, rs_valid, rs_match, busy}), 32'd0);
            chk("rst_tc", 32'({tc_data_in, tc_mask}), 32'd0);
            chk("rst_addr_num", 32'({tc_addr_in, rs_num}), 32'd0);
            chk("rst_cnts", 32'({hit_cnt, miss_cnt}), 32'd0);
        end
        rstN = 1'b1;
        #1;
        chk("first_tie_wr", 32'(wr_ready), 32'd1);
        chk("first_tie_lk", 32'(lk_ready), 32'd0);
        wr_valid = 1'b0; lk_valid = 1'b0;

        // Back-to-back writes; the first one is also a tie.
        step(1'b1, 1'b1, 16'hABCD, 16'h0F0F, 4'd0, 16'h5555, 0, g, m, n);
        step(1'b1, 1'b0, 16'hCDEF, 16'hFF00, 4'd1, 16'h0, 0, g, m, n);
        step(1'b1, 1'b0, 16'h50C9, 16'hC32C, 4'd2, 16'h0, 0, g, m, n);
        @(negedge clk);
        chk("wr_pulses", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            chk("wr_spacing0", 32'(wq[1] - wq[0]), 32'd2);
            chk("wr_spacing1", 32'(wq[2] - wq[1]), 32'd2);
        end
        chk("wr_no_re", 32'(n_rpulse), 32'd0);

        // Directed lookups, including a backpressured miss.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'h0, 16'h0, 4'd0, vec[i].key, vec[i].hold, g, m, n);
            chk("vec_match", 32'(m), 32'(vec[i].m));
            chk("vec_num", 32'(n), 32'(vec[i].n));
        end

        // Contention: both sides requesting for four grants.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h1234, 16'h0000, 4'hF, 16'h1234, 0, g, m, n);
            chk("contention_order", 32'(g), 32'(i % 2));
        end

        // Randomised mix against the shadow model.
        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 2));
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            rm = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                j  = int'($urandom_range(0, 15));
                rk = sh_d[j] ^ (16'($urandom) & sh_m[j]);
            end else begin
                rk = 16'($urandom);
            end
            step(op != 1, op != 0, rd, rm, ra, rk, int'($urandom_range(0, 2)), g, m, n);
        end
        @(negedge clk);
        @(negedge clk);
        chk("total_w_pulses", 32'(n_wpulse), 32'(n_wr));
        chk("total_r_pulses", 32'(n_rpulse), 32'(n_lk));

        // TCAM_LAT=3 instance: latency, then reset while waiting on the TCAM.
        @(negedge clk);
        b_rstN = 1'b1;
        @(negedge clk);
        b_lk_key = 16'h0001; b_lk_valid = 1'b1;
        #1;
        chk("l3_ready", 32'(b_lk_ready), 32'd1);
        acc = cyc;
        @(negedge clk);
        b_lk_valid = 1'b0;
        chk("l3_re", 32'({b_tc_r_e, b_tc_w_e, b_wr_ready}), 32'd4);
        chk("l3_tc", 32'({b_tc_data_in, b_tc_mask, b_tc_addr_in}), 32'({16'h0001, 16'h0, 4'h0}));
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b_rs_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("l3_rs_seen", 32'(got), 32'd1);
        chk("l3_latency", 32'(cyc - acc), 32'd5);
        chk("l3_match", 32'(b_rs_match), 32'd1);
        chk("l3_num", 32'(b_rs_num), 32'h5A5B);
        b_rs_ready = 1'b1;
        @(negedge clk);
        b_rs_ready = 1'b0;
        chk("l3_hit", 32'({b_hit_cnt, b_miss_cnt}), 32'h0001_0000);
        $display("txn L3 key=0001 latency=%0d", cyc - acc);

        b_lk_key = 16'h0002; b_lk_valid = 1'b1;
        #1;
        chk("l3b_ready", 32'(b_lk_ready), 32'd1);
        repeat (3) @(negedge clk);
        b_lk_valid = 1'b0;
        chk("l3b_busy_in_wait", 32'({b_busy, b_rs_valid}), 32'd2);
        b_rstN = 1'b0;
        @(negedge clk);
        b_rstN = 1'b1;
        b_rs_ready = 1'b1;
        chk("l3b_rst_busy", 32'(b_busy), 32'd0);
        chk("l3b_rst_cnts", 32'({b_hit_cnt, b_miss_cnt}), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b_rs_valid || b_busy) seen = 1'b1;
        end
        chk("l3b_no_resp", 32'(seen), 32'd0);
        $display("txn L3 key=0002 dropped by reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
